rf_wr_arbiter: RTL and testbench

Sequencer and arbiter for the single write port of the 2R1W register file.
- After reset, walks every register address writing zero, because register contents themselves have no reset.
- Then shares the write port between two writeback requesters (port 0 = ALU, port 1 = load unit) using valid/ready handshakes and round-robin priority.
- Drives wr_en/wr_addr/wr_data of the register file directly from registered outputs.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rr_arb2.sv | 17 +
 rtl/rf_wr_arbiter.sv | 111 +++++++++++
 tb/tb_rf_wr_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register file and its write-port sequencer.
package rf_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic. Purely combinational; the caller owns the
// priority flop and flips it after each transfer.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       prio,
  output logic [1:0] grant
);

  // A lone requester always wins; on contention the prio bit picks the port.
  always_comb begin
    grant = 2'b00;
    if (valid0 && (!valid1 || !prio)) grant[0] = 1'b1;
    if (valid1 && (!valid0 || prio))  grant[1] = 1'b1;
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Owner of the register file write port. After reset it zeroes every register
// (the file itself has no reset), then shares the port between the ALU (port 0)
// and the load unit (port 1) with round-robin priority. All write-port outputs
// come straight from flops.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH     = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = RF_DATA_WIDTH,
  parameter int NUM_REGS       = 32,
  parameter bit ZERO_REG_RO    = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  rf_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  prio, prio_nxt;
  logic                  wr_en_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic                  init_done_nxt;
  logic [1:0]            grant;
  logic                  xfer0, xfer1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .prio   (prio),
    .grant  (grant)
  );

  assign req0_ready = (state == ST_RUN) && grant[0];
  assign req1_ready = (state == ST_RUN) && grant[1];
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign sel_addr   = xfer1 ? req1_addr : req0_addr;
  assign sel_data   = xfer1 ? req1_data : req0_data;

  // Next-state and next-output logic: clear sweep first, then one accepted write per cycle.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    prio_nxt      = prio;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    init_done_nxt = init_done;
    case (state)
      ST_CLEAR: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = cnt;
        wr_data_nxt = '0;
        cnt_nxt     = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST_ADDR) begin
          state_nxt     = ST_RUN;
          init_done_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (xfer0 || xfer1) begin
          wr_addr_nxt = sel_addr;
          wr_data_nxt = sel_data;
          wr_en_nxt   = !(ZERO_REG_RO && (sel_addr == '0));
          prio_nxt    = xfer0;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // State and output registers; reset aborts any sweep or pending handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      init_done <= ~CLEAR_ON_RESET;
      cnt       <= '0;
      prio      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      init_done <= init_done_nxt;
      cnt       <= cnt_nxt;
      prio      <= prio_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: a reference model predicts every register file write
// and pushes it into a queue tagged with the cycle it must appear; a monitor
// pops and compares against the write port. A second instance covers the
// no-clear reset variant.
module tb_rf_wr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  localparam int MODE_HOLD    = 0;
  localparam int MODE_CONTEND = 1;
  localparam int MODE_RANDOM  = 2;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, wr_addr;
  logic [DW-1:0] req0_data, req1_data, wr_data;
  logic          wr_en, init_done;

  logic          nc_req0_valid, nc_req1_valid, nc_req0_ready, nc_req1_ready;
  logic [AW-1:0] nc_req0_addr, nc_req1_addr, nc_wr_addr;
  logic [DW-1:0] nc_req0_data, nc_req1_data, nc_wr_data;
  logic          nc_wr_en, nc_init_done;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   base = 0;
  bit   was_reset = 1'b1;
  bit   turn = 1'b0;
  bit   run_m, g0, g1, due_now;

  rf_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done)
  );

  rf_wr_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst),
    .req0_valid(nc_req0_valid), .req0_ready(nc_req0_ready), .req0_addr(nc_req0_addr), .req0_data(nc_req0_data),
    .req1_valid(nc_req1_valid), .req1_ready(nc_req1_ready), .req1_addr(nc_req1_addr), .req1_data(nc_req1_data),
    .wr_en(nc_wr_en), .wr_addr(nc_wr_addr), .wr_data(nc_wr_data), .init_done(nc_init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, wr_data, 32'd0);
    checkOutput({tag, "_init_done"}, 32'(init_done), 32'd0);
    checkOutput({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
    checkOutput({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
    checkOutput({tag, "_nc_init_done"}, 32'(nc_init_done), 32'd1);
    checkOutput({tag, "_nc_wr_en"}, 32'(nc_wr_en), 32'd0);
  endtask

  // A requester only changes its request when idle or just accepted.
  task automatic updatePort(input int mode, input bit acc, inout logic valid,
                            inout logic [AW-1:0] addr, inout logic [DW-1:0] data);
    if (!valid || acc) begin
      case (mode)
        MODE_HOLD: if (acc) valid = 1'b0;
        MODE_CONTEND: begin
          valid = 1'b1;
          addr  = AW'($urandom_range(1, NR - 1));
          data  = $urandom;
        end
        default: begin
          valid = ($urandom_range(0, 3) != 0);
          addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NR - 1));
          data  = $urandom;
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input int n, input int mode);
    bit acc0, acc1;
    repeat (n) begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      updatePort(mode, acc0, req0_valid, req0_addr, req0_data);
      updatePort(mode, acc1, req1_valid, req1_addr, req1_data);
    end
  endtask

  // Reference model: clear sweep occupies the first NR edges after release,
  // then each accepted request shows up on the write port one edge later.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      turn      = 1'b0;
      was_reset = 1'b1;
    end else begin
      if (was_reset) begin
        was_reset = 1'b0;
        base = cyc;
        for (int i = 0; i < NR; i++) exp_q.push_back('{due: base + i + 1, addr: AW'(i), data: '0});
      end
      run_m = (cyc >= base + NR);
      g0 = run_m && req0_valid && (!req1_valid || turn == 1'b0);
      g1 = run_m && req1_valid && (!req0_valid || turn == 1'b1);
      checkOutput("init_done", 32'(init_done), 32'(run_m));
      checkOutput("req0_ready", 32'(req0_ready), 32'(g0));
      checkOutput("req1_ready", 32'(req1_ready), 32'(g1));
      if (g0) begin
        if (req0_addr != 0) exp_q.push_back('{due: cyc + 1, addr: req0_addr, data: req0_data});
        turn = 1'b1;
      end else if (g1) begin
        if (req1_addr != 0) exp_q.push_back('{due: cyc + 1, addr: req1_addr, data: req1_data});
        turn = 1'b0;
      end
    end
  end

  // Monitor: the write port must be active exactly when a predicted write is due.
  always @(negedge clk) begin
    if (!rst) begin
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      checkOutput("wr_en", 32'(wr_en), 32'(due_now));
      if (due_now) begin
        checkOutput("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
        checkOutput("wr_data", wr_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  // No-clear instance: usable on the first cycle after release.
  initial begin
    @(negedge rst);
    @(negedge clk);
    checkOutput("nc_init_done", 32'(nc_init_done), 32'd1);
    checkOutput("nc_req0_ready", 32'(nc_req0_ready), 32'd1);
    checkOutput("nc_wr_en_first", 32'(nc_wr_en), 32'd0);
    @(negedge clk);
    checkOutput("nc_wr_en", 32'(nc_wr_en), 32'd1);
    checkOutput("nc_wr_addr", 32'(nc_wr_addr), 32'd7);
    checkOutput("nc_wr_data", nc_wr_data, 32'hA5A5_5A5A);
  end

  initial begin
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    nc_req0_valid = 1'b1; nc_req0_addr = 5'd7; nc_req0_data = 32'hA5A5_5A5A;
    nc_req1_valid = 1'b0; nc_req1_addr = '0;   nc_req1_data = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 checkReset("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(10, MODE_HOLD);
    rst = 1'b1;
    #1 checkReset("mid");
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(40, MODE_HOLD);
    applyStimulus(30, MODE_CONTEND);
    applyStimulus(400, MODE_RANDOM);
    applyStimulus(10, MODE_HOLD);
    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
